// File: rtl/cic_pkg.sv
// Shared definitions for the sinc^N decimator: filter order, register width rule
// and the default signed accumulator type.
package cic_pkg;

  localparam int CIC_ORDER      = 3;
  localparam int CIC_DEF_LOG2_R = 4;

  // Peak magnitude is R^order for a +/-1 input.
  // One extra bit represents +R^order and one more carries the sign.
  function automatic int cic_width(input int order, input int log2_r);
    return order * log2_r + 2;
  endfunction

  typedef logic signed [cic_width(CIC_ORDER, CIC_DEF_LOG2_R)-1:0] cic_acc_t;

endpackage

// File: rtl/cic_integ_stage.sv
// One wrapping W-bit integrator with enable and asynchronous clear.
// sum is the post-add value, so cascaded stages all advance on the same edge.
module cic_integ_stage
  import cic_pkg::*;
#(
  parameter int W = cic_width(CIC_ORDER, CIC_DEF_LOG2_R)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] sum
);

  logic signed [W-1:0] acc;

  // Modulo-2^W wrap is intentional; the combs cancel it exactly.
  assign sum = acc + din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/cic3_decimator.sv
// Third-order CIC decimator (differential delay 1) from a 1-bit sigma-delta stream to PCM.
// Defining CIC_ROUND_SAT_EN adds round-half-up and saturation to the output scaling.
module cic3_decimator
  import cic_pkg::*;
#(
  parameter int LOG2_R = 4,
  parameter int OUT_BW = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bs_in,
  input  logic                     bs_valid,
  output logic signed [OUT_BW-1:0] dout,
  output logic                     dout_valid
);

  localparam int W     = cic_width(CIC_ORDER, LOG2_R);
  localparam int SHIFT = W - OUT_BW;

  typedef logic signed [W-1:0] acc_t;

  localparam acc_t                ONE     = acc_t'(1);
  localparam logic [LOG2_R-1:0]   PH_LAST = '1;

`ifdef CIC_ROUND_SAT_EN
  localparam logic signed [W:0] RND    = (W+1)'((1 << SHIFT) >> 1);
  localparam logic signed [W:0] SAT_HI = (W+1)'((1 << (OUT_BW-1)) - 1);
  localparam logic signed [W:0] SAT_LO = (W+1)'(-(1 << (OUT_BW-1)));
`endif

  function automatic logic signed [OUT_BW-1:0] scale(input acc_t v);
`ifdef CIC_ROUND_SAT_EN
    logic signed [W:0] t;
    t = (W+1)'(v) + RND;
    t = t >>> SHIFT;
    if (t > SAT_HI) begin
      t = SAT_HI;
    end else if (t < SAT_LO) begin
      t = SAT_LO;
    end
    return OUT_BW'(t);
`else
    return OUT_BW'(v >>> SHIFT);
`endif
  endfunction

  acc_t              x;
  acc_t              i1_sum, i2_sum, i3_sum;
  acc_t              d1, d2, d3;
  acc_t              c1, c2, c3;
  logic [LOG2_R-1:0] phase;
  logic              strike;

  assign x = bs_in ? ONE : -ONE;

  cic_integ_stage #(.W(W)) u_integ1 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (bs_valid),
    .din  (x),
    .sum  (i1_sum)
  );

  cic_integ_stage #(.W(W)) u_integ2 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (bs_valid),
    .din  (i1_sum),
    .sum  (i2_sum)
  );

  cic_integ_stage #(.W(W)) u_integ3 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (bs_valid),
    .din  (i2_sum),
    .sum  (i3_sum)
  );

  // Decimated-rate combs, evaluated only on the edge that closes a frame.
  assign strike = bs_valid && (phase == PH_LAST);
  assign c1     = i3_sum - d1;
  assign c2     = c1 - d2;
  assign c3     = c2 - d3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= '0;
      d1         <= '0;
      d2         <= '0;
      d3         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= strike;
      if (bs_valid) begin
        phase <= phase + 1'b1;
      end
      if (strike) begin
        d1   <= i3_sum;
        d2   <= c1;
        d3   <= c2;
        dout <= scale(c3);
      end
    end
  end

endmodule
